// File: rtl/dma_axi_write_engine.sv
// Single-outstanding-burst AXI write master: pops words from a FIFO and writes
// len_words words to dst_addr as INCR bursts of at most MAX_BURST beats.
module dma_axi_write_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    len_words,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, ADDR, FETCH, DATA, RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [8:0]            burst_q;
    logic [7:0]            awlen_q;
    logic [7:0]            beat_cnt;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  data_fresh;
    logic                  done_q;
    logic                  error_q;

    logic [LEN_WIDTH-1:0]  rem_after;
    logic [ADDR_WIDTH-1:0] addr_after;
    logic [8:0]            burst_start;
    logic [8:0]            burst_next;

    function automatic logic [8:0] burst_of(input logic [LEN_WIDTH-1:0] rem);
        if (32'(rem) > MAX_BURST) return 9'(MAX_BURST);
        return 9'(rem);
    endfunction

    assign rem_after   = remaining_q - LEN_WIDTH'(burst_q);
    assign addr_after  = addr_q + (ADDR_WIDTH'(burst_q) << SIZE_LOG2);
    assign burst_start = burst_of(len_words);
    assign burst_next  = burst_of(rem_after);

    assign done      = done_q;
    assign error     = error_q;
    assign m_awaddr  = addr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = 3'(SIZE_LOG2);
    assign m_awburst = 2'b01;
    assign m_wstrb   = '1;
    assign m_wlast   = (state == DATA) && (beat_cnt == awlen_q);
    // The popped word arrives in the first DATA cycle; drive it straight
    // through then, and from the capture register for any stalled cycles.
    assign m_wdata   = data_fresh ? fifo_rd_data : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        m_awvalid  = 1'b0;
        fifo_rd_en = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && len_words != '0) state_nxt = ADDR;
            end
            ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) state_nxt = FETCH;
            end
            FETCH: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) state_nxt = DATA;
            end
            DATA: begin
                m_wvalid = 1'b1;
                if (m_wready) state_nxt = m_wlast ? RESP : FETCH;
            end
            RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nxt = (rem_after != '0) ? ADDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            awlen_q     <= '0;
            beat_cnt    <= '0;
            wdata_q     <= '0;
            data_fresh  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            data_fresh <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_words != '0) begin
                            addr_q      <= dst_addr;
                            remaining_q <= len_words;
                            burst_q     <= burst_start;
                            awlen_q     <= 8'(burst_start - 9'd1);
                            error_q     <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (m_awready) beat_cnt <= '0;
                end
                FETCH: begin
                    if (!fifo_empty) data_fresh <= 1'b1;
                end
                DATA: begin
                    if (data_fresh) wdata_q <= fifo_rd_data;
                    if (m_wready && !m_wlast) beat_cnt <= beat_cnt + 8'd1;
                end
                RESP: begin
                    if (m_bvalid) begin
                        // Error responses are recorded but the transfer carries on.
                        if (m_bresp[1]) error_q <= 1'b1;
                        remaining_q <= rem_after;
                        addr_q      <= addr_after;
                        if (rem_after != '0) begin
                            burst_q <= burst_next;
                            awlen_q <= 8'(burst_next - 9'd1);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dma_axi_write_engine.md
DMA_AXI_WRITE_ENGINE -- requirements
Module: dma_axi_write_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the AXI W and FIFO data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI address width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum beats per AXI burst (1..256).
REQ-004 The block SHALL have parameter LEN_WIDTH, default 16, meaning the transfer-length counter width in words.
REQ-005 Ports (name, direction, width, meaning) SHALL be exactly:
- clk, in, 1, the single clock; all logic on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse that launches a transfer.
- dst_addr, in, ADDR_WIDTH, word-aligned destination byte address.
- len_words, in, LEN_WIDTH, number of words to write.
- busy, out, 1, transfer in progress.
- done, out, 1, one-cycle completion pulse.
- error, out, 1, sticky flag: any BRESP was SLVERR or DECERR.
- fifo_rd_en, out, 1, FIFO pop request.
- fifo_rd_data, in, DATA_WIDTH, FIFO data, valid the cycle after an accepted pop.
- fifo_empty, in, 1, FIFO empty flag.
- AW channel: m_awaddr (out, ADDR_WIDTH), m_awlen (out, 8), m_awsize (out, 3), m_awburst (out, 2), m_awvalid (out, 1), m_awready (in, 1).
- W channel: m_wdata (out, DATA_WIDTH), m_wstrb (out, DATA_WIDTH/8), m_wlast (out, 1), m_wvalid (out, 1), m_wready (in, 1).
- B channel: m_bresp (in, 2), m_bvalid (in, 1), m_bready (out, 1).

Function
REQ-006 The state machine SHALL use the states IDLE, ADDR, FETCH, DATA and RESP.
REQ-007 In IDLE, start with len_words != 0 SHALL latch dst_addr and len_words, clear error, and enter ADDR next cycle.
REQ-008 In IDLE, start with len_words == 0 SHALL pulse done for one cycle next cycle, leave error unchanged, and remain in IDLE.
REQ-009 start SHALL be ignored whenever busy=1.
REQ-010 busy SHALL be 1 in every state except IDLE.
REQ-011 The burst size SHALL be min(remaining, MAX_BURST), and m_awlen SHALL equal burst size - 1.
REQ-012 m_awsize SHALL be log2(DATA_WIDTH/8), m_awburst SHALL be 2'b01 (INCR), and m_wstrb SHALL be all ones.
REQ-013 In ADDR, m_awvalid SHALL be 1, and m_awaddr and m_awlen SHALL be held stable until m_awready.
REQ-014 On the m_awvalid & m_awready handshake, the beat counter SHALL clear to 0 and the state SHALL move to FETCH.
REQ-015 In FETCH, fifo_rd_en SHALL equal !fifo_empty.
REQ-016 When fifo_empty=0 in FETCH, the state SHALL move to DATA; otherwise it SHALL stay in FETCH indefinitely.
REQ-017 fifo_rd_en SHALL be 0 in every state other than FETCH, so that no pop is issued while a beat is outstanding.
REQ-018 On DATA entry, fifo_rd_data SHALL be captured into m_wdata and held stable while m_wvalid=1 and m_wready=0.
REQ-019 In DATA, m_wvalid SHALL be 1, and m_wlast SHALL be 1 exactly when beat counter = burst size - 1.
REQ-020 On a W handshake with m_wlast=0, the beat counter SHALL increment and the state SHALL return to FETCH.
REQ-021 On a W handshake with m_wlast=1, the state SHALL move to RESP.
REQ-022 Sustained throughput SHALL be one beat per two cycles.
REQ-023 In RESP, m_bready SHALL be 1.
REQ-024 On m_bvalid in RESP, m_bresp[1]=1 SHALL set error, the remaining count SHALL decrease by the burst size, and the address SHALL advance by burst size × (DATA_WIDTH/8).
REQ-025 After the B handshake, remaining != 0 SHALL move the state to ADDR, and remaining == 0 SHALL move the state to IDLE with a one-cycle done pulse.
REQ-026 An error response SHALL NOT abort the transfer, and error SHALL remain set until the next accepted start.
REQ-027 Address arithmetic SHALL be ADDR_WIDTH wide and wrap modulo 2^ADDR_WIDTH.
REQ-028 Splitting bursts at 4KB boundaries is out of scope; software SHALL program dst_addr and len_words so that no burst crosses a 4KB boundary.
REQ-029 The AW, W and B channels SHALL be strictly serialized: there is one outstanding burst, and no W beat is issued before its AW handshake.

Reset
REQ-030 rst_n low SHALL force, asynchronously, state=IDLE and busy=0, done=0, error=0.
REQ-031 rst_n low SHALL force, asynchronously, fifo_rd_en=0, m_awvalid=0, m_wvalid=0, m_wlast=0 and m_bready=0.
REQ-032 rst_n low SHALL force, asynchronously, m_awaddr=0, m_awlen=0 and m_wdata=0.
REQ-033 A reset asserted mid-transfer SHALL abandon the transfer, with no done pulse after reset release.

Verification
REQ-034 A bench SHALL cover: start dst_addr=0x1000, len=4, FIFO preloaded with A0..A3, all readies high -> one AW (addr 0x1000, awlen 3), W beats A0..A3 with wlast on the 4th, done=1 for one cycle, error=0.
REQ-035 A bench SHALL cover: len=20, MAX_BURST=16, dst_addr=0x2000 -> AW 0x2000/awlen 15, then AW 0x2040/awlen 3, 20 beats total, one done pulse.
REQ-036 A bench SHALL cover: fifo_empty=1 for 10 cycles mid-burst -> fifo_rd_en=0, m_wvalid=0, state stays FETCH; transfer resumes with no data loss after data arrives.
REQ-037 A bench SHALL cover: m_wready low for 5 cycles -> m_wdata and m_wlast stable, and no extra fifo_rd_en pulse.
REQ-038 A bench SHALL cover: bresp=2'b10 on burst 1 of 2 -> error=1, burst 2 still issued, done pulses, error held until next start.
REQ-039 A bench SHALL cover: start with len=0 -> no AW issued, done pulse next cycle; rst_n low during DATA -> all outputs zero immediately and busy=0.
